// File: rtl/dcache_wb_if.sv
// Pipeline-side and memory-side signals of the write-back data cache.
// The cache uses the slave view; the pipeline and memory models use the master view.
interface dcache_wb_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines x 4 words x 32 b.
// Hits complete in the request cycle; misses stall while a dirty victim is written back and the line refilled.
module dcache_wb (
    input  logic        clk,
    input  logic        rst_n,
    dcache_wb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_e;

    state_e       state_q;
    logic [7:0]   valid_q;
    logic [7:0]   dirty_q;
    logic [24:0]  tag_q  [8];
    logic [127:0] data_q [8];
    logic         mem_read_q;
    logic         mem_write_q;
    logic [27:0]  mem_addr_q;
    logic [127:0] mem_wdata_q;

    logic [24:0]  req_tag;
    logic [2:0]   idx;
    logic [1:0]   off;
    logic         req;
    logic         hit;

    assign req_tag = bus.proc_addr[29:5];
    assign idx     = bus.proc_addr[4:2];
    assign off     = bus.proc_addr[1:0];
    assign req     = bus.proc_read | bus.proc_write;
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

    assign bus.proc_stall = (state_q != S_IDLE) || (req && !hit);
    assign bus.proc_rdata = data_q[idx][{off, 5'd0} +: 32];
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // NOTE: every piece of state, including the data array, is assigned with <= so all
    // lines update together at the edge; the data array is reset too, which keeps
    // proc_rdata defined (not X) right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req && hit) begin
                        if (bus.proc_write) begin
                            data_q[idx][{off, 5'd0} +: 32] <= bus.proc_wdata;
                            dirty_q[idx]                   <= 1'b1;
                        end
                    end else if (req && valid_q[idx] && dirty_q[idx]) begin
                        state_q     <= S_WRITEBACK;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {tag_q[idx], idx};
                        mem_wdata_q <= data_q[idx];
                    end else if (req) begin
                        state_q    <= S_ALLOCATE;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= {req_tag, idx};
                    end
                end
                S_WRITEBACK: begin
                    // Dirty bit stays set until the refill overwrites the line.
                    if (bus.mem_ready) begin
                        state_q     <= S_ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {req_tag, idx};
                    end
                end
                S_ALLOCATE: begin
                    // A pending store is not merged here; it retires as a hit next cycle.
                    if (bus.mem_ready) begin
                        state_q      <= S_IDLE;
                        mem_read_q   <= 1'b0;
                        data_q[idx]  <= bus.mem_rdata;
                        tag_q[idx]   <= req_tag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
